// File: rtl/ram_readback_unpacker_pkg.sv
// Shared types and width helpers for the RAM readback unpacker.
package ram_readback_unpacker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit,
    StFinish
  } state_e;

  // A result word carries one extra digit beyond no_of_digits (sign/overflow digit).
  function automatic int unsigned word_width(input int unsigned digits,
                                             input int unsigned radix);
    return (digits + 1) * radix;
  endfunction

  localparam int unsigned DefaultWordW = word_width(10, 3);

endpackage

// File: rtl/burst_lane_mux.sv
// Combinational selection of one WordW-bit lane out of a packed burst.
module burst_lane_mux #(
  parameter int unsigned WordW = 33,
  parameter int unsigned Lanes = 5,
  parameter int unsigned LaneW = 3
) (
  input  logic [WordW*Lanes-1:0] burst_i,
  input  logic [LaneW-1:0]       lane_i,
  output logic [WordW-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < Lanes; k++) begin
      if (lane_i == LaneW'(k)) begin
        data_o = burst_i[k*WordW +: WordW];
      end
    end
  end

endmodule

// File: rtl/ram_readback_unpacker.sv
// Reads a RAM pass word by word and streams each packed result lane out with handshake.
module ram_readback_unpacker
  import ram_readback_unpacker_pkg::*;
#(
  parameter int unsigned no_of_digits    = 10,
  parameter int unsigned radix_bits      = 3,
  parameter int unsigned burst_index     = 5,
  parameter int unsigned address_width   = 14,
  parameter int unsigned max_ram_address = 4096,
  parameter int unsigned rd_latency      = 2,
  localparam int unsigned W              = word_width(no_of_digits, radix_bits)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [address_width-1:0]   ram_addr,
  input  logic [W*burst_index-1:0]   ram_q,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LaneW = (burst_index > 1) ? $clog2(burst_index) : 1;
  localparam int unsigned WaitW = $clog2(rd_latency + 1);
  localparam logic [LaneW-1:0] LastLane = LaneW'(burst_index - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(rd_latency - 1);
  localparam logic [address_width-1:0] LastAddr = address_width'(max_ram_address - 1);

  state_e                   state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [LaneW-1:0]         lane_q, lane_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic [W*burst_index-1:0] buf_q, buf_d;
  logic [W-1:0]             lane_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lane_q  <= '0;
      wait_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      wait_q  <= wait_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    wait_d  = wait_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // ram_q is valid in the last wait cycle; capture it on that edge.
        if (wait_q == LastWait) begin
          buf_d   = ram_q;
          lane_d  = '0;
          state_d = StEmit;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (lane_q == LastLane) begin
            lane_d = '0;
            if (addr_q == LastAddr) begin
              state_d = StFinish;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = StIssue;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  burst_lane_mux #(
    .WordW(W),
    .Lanes(burst_index),
    .LaneW(LaneW)
  ) u_lane_mux (
    .burst_i(buf_q),
    .lane_i (lane_q),
    .data_o (lane_data)
  );

  always_comb begin
    ram_addr  = addr_q;
    out_valid = (state_q == StEmit);
    out_data  = out_valid ? lane_data : '0;
    out_last  = out_valid && (lane_q == LastLane) && (addr_q == LastAddr);
    busy      = (state_q != StIdle);
    done      = (state_q == StFinish);
  end

endmodule

// File: tb/tb_ram_readback_unpacker.sv
// Self-checking bench: full default pass, abort/restart, and a small instance with backpressure.
module tb_ram_readback_unpacker;
  import ram_readback_unpacker_pkg::*;

  localparam int unsigned W    = word_width(10, 3);
  localparam int unsigned B    = 5;
  localparam int unsigned AW   = 14;
  localparam int unsigned MaxA = 4096;
  localparam int unsigned MaxB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic          rst_a, start_a, ready_a, valid_a, last_a, busy_a, done_a;
  logic [AW-1:0] ram_addr_a;
  logic [W*B-1:0] q_a;
  logic [W-1:0]  data_a;

  // DUT B: two RAM words, single-cycle read latency
  logic          rst_b, start_b, ready_b, valid_b, last_b, busy_b, done_b;
  logic [AW-1:0] ram_addr_b;
  logic [W*B-1:0] q_b;
  logic [W-1:0]  data_b;

  ram_readback_unpacker u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .ram_addr(ram_addr_a), .ram_q(q_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  ram_readback_unpacker #(
    .max_ram_address(MaxB),
    .rd_latency(1)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .ram_addr(ram_addr_b), .ram_q(q_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  // RAM models: address pipelined by the read latency
  logic [AW-1:0] a_d1, a_d2, b_d1;
  logic [W-1:0]  mem_b [MaxB][B];

  always_ff @(posedge clk) begin
    a_d1 <= ram_addr_a;
    a_d2 <= a_d1;
    b_d1 <= ram_addr_b;
  end

  always_comb begin
    q_a = '0;
    for (int k = 0; k < int'(B); k++) q_a[k*W +: W] = W'(int'(a_d2) * int'(B) + k);
  end

  always_comb begin
    q_b = '0;
    if (b_d1 < AW'(MaxB))
      for (int k = 0; k < int'(B); k++) q_b[k*W +: W] = mem_b[b_d1[0]][k];
  end

  int errors = 0;
  int checks = 0;

  int exp_a, done_cnt_a, last_cnt_a, busy_cyc_a, done_cnt_b;
  logic [W-1:0] exp_q[$];
  logic         prev_stall_b;
  logic [W-1:0] prev_data_b;

  typedef struct {
    logic          ready;
    logic          valid;
    logic          busy;
    logic          last;
    logic          done;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic v, input logic b, input logic l, input logic d,
                              input int a);
    vec_t r;
    r.ready = 1'b1;
    r.valid = v;
    r.busy  = b;
    r.last  = l;
    r.done  = d;
    r.addr  = AW'(a);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_a();
    if (!rst_a) return;
    if (valid_a && ready_a) begin
      check("a_data", 64'(data_a), 64'(exp_a));
      check("a_last", 64'(last_a), 64'(exp_a == int'(MaxA * B) - 1));
      if (last_a) last_cnt_a++;
      exp_a++;
    end
    if (done_a) done_cnt_a++;
    if (busy_a) busy_cyc_a++;
  endtask

  task automatic mon_b();
    logic [W-1:0] dummy;
    if (!rst_b) begin
      prev_stall_b = 1'b0;
      return;
    end
    if (prev_stall_b) begin
      check("b_hold_valid", 64'(valid_b), 64'd1);
      check("b_hold_data", 64'(data_b), 64'(prev_data_b));
    end
    if (valid_b && ready_b) begin
      check("b_word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("b_data", 64'(data_b), 64'(exp_q[0]));
        check("b_last", 64'(last_b), 64'(exp_q.size() == 1));
        dummy = exp_q.pop_front();
      end
    end
    if (done_b) done_cnt_b++;
    prev_stall_b = valid_b && !ready_b;
    prev_data_b  = data_b;
  endtask

  task automatic tick();
    mon_a();
    mon_b();
    @(negedge clk);
  endtask

  task automatic fill_b();
    exp_q.delete();
    for (int a = 0; a < int'(MaxB); a++)
      for (int k = 0; k < int'(B); k++) begin
        mem_b[a][k] = W'({$urandom(), $urandom()});
        exp_q.push_back(mem_b[a][k]);
      end
  endtask

  task automatic run_pass_b(input bit random_ready);
    int  d0;
    int  cyc;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    fill_b();
    d0 = done_cnt_b;
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (exp_q.size() == 0 && !busy_b) break;
      ready_b = random_ready ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      tick();
    end
    check("b_pass_in_time", 64'(cyc < 400), 64'd1);
    check("b_drained", 64'(exp_q.size()), 64'd0);
    check("b_done_once", 64'(done_cnt_b - d0), 64'd1);
    ready_b = 1'b1;
  endtask

  initial begin
    int d0, l0, bc0, cyc;
    bit pulsed;

    vecs[0] = mk(0, 1, 0, 0, 0);
    vecs[1] = mk(0, 1, 0, 0, 0);
    for (int r = 2; r <= 6; r++) vecs[r] = mk(1, 1, 0, 0, 0);
    vecs[7] = mk(0, 1, 0, 0, 1);
    vecs[8] = mk(0, 1, 0, 0, 1);
    for (int r = 9; r <= 12; r++) vecs[r] = mk(1, 1, 0, 0, 1);
    vecs[13] = mk(1, 1, 1, 0, 1);
    vecs[14] = mk(0, 1, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 1);

    rst_a = 1'b0; start_a = 1'b0; ready_a = 1'b1;
    rst_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;
    exp_a = 0; done_cnt_a = 0; last_cnt_a = 0; busy_cyc_a = 0; done_cnt_b = 0;
    prev_stall_b = 1'b0; prev_data_b = '0;
    repeat (3) tick();

    check("rst_addr", 64'(ram_addr_a), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_last", 64'(last_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_b_busy", 64'(busy_b), 64'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // Small instance: cycle-exact table with out_ready held high
    fill_b();
    d0 = done_cnt_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int r = 0; r < 17; r++) begin
      ready_b = vecs[r].ready;
      check($sformatf("tbl%0d_valid", r), 64'(valid_b), 64'(vecs[r].valid));
      check($sformatf("tbl%0d_busy", r), 64'(busy_b), 64'(vecs[r].busy));
      check($sformatf("tbl%0d_last", r), 64'(last_b), 64'(vecs[r].last));
      check($sformatf("tbl%0d_done", r), 64'(done_b), 64'(vecs[r].done));
      check($sformatf("tbl%0d_addr", r), 64'(ram_addr_b), 64'(vecs[r].addr));
      tick();
    end
    check("tbl_drained", 64'(exp_q.size()), 64'd0);
    check("tbl_done_once", 64'(done_cnt_b - d0), 64'd1);

    run_pass_b(1'b0);
    for (int p = 0; p < 3; p++) run_pass_b(1'b1);

    // Full default pass, with a stray start at address 7 during EMIT
    exp_a = 0;
    d0 = done_cnt_a; l0 = last_cnt_a; bc0 = busy_cyc_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pulsed = 1'b0;
    for (cyc = 0; cyc < 40000 && done_cnt_a == d0; cyc++) begin
      start_a = !pulsed && valid_a && (ram_addr_a == AW'(7));
      if (start_a) pulsed = 1'b1;
      tick();
      start_a = 1'b0;
    end
    check("a_pass_in_time", 64'(done_cnt_a != d0), 64'd1);
    repeat (10) tick();
    check("a_word_count", 64'(exp_a), 64'(MaxA * B));
    check("a_done_once", 64'(done_cnt_a - d0), 64'd1);
    check("a_last_once", 64'(last_cnt_a - l0), 64'd1);
    check("a_busy_cycles", 64'(busy_cyc_a - bc0), 64'(MaxA * (1 + 2 + B) + 1));
    check("a_idle_after", 64'(busy_a), 64'd0);
    check("a_addr_no_wrap", 64'(ram_addr_a), 64'(MaxA - 1));

    // Abort during WAIT at address 100, then restart from address 0
    exp_a = 0;
    d0 = done_cnt_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (ram_addr_a == AW'(100) && busy_a && !valid_a) break;
      tick();
    end
    check("a_reach_100", 64'(cyc < 2000), 64'd1);
    tick();
    check("a_wait_addr", 64'(ram_addr_a), 64'd100);
    check("a_wait_valid", 64'(valid_a), 64'd0);
    #2 rst_a = 1'b0;
    #1;
    check("abort_valid", 64'(valid_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_addr", 64'(ram_addr_a), 64'd0);
    check("abort_data", 64'(data_a), 64'd0);
    tick();
    tick();
    rst_a = 1'b1;
    tick();
    check("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
    exp_a = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_addr", 64'(ram_addr_a), 64'd0);
    check("restart_busy", 64'(busy_a), 64'd1);
    repeat (40) tick();
    check("restart_words", 64'(exp_a), 64'd25);
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
